// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller with instruction register and BSR strobe decode.
// Optional IDCODE data register enabled by defining TAP_IDCODE_EN.
//
// state  | meaning
// -------+----------------------------------------------
// TLR  F | test-logic-reset, IR forced to reset instruction
// RTI  C | run-test/idle
// SDR  7 | select-DR-scan
// CDR  6 | capture-DR (BSC capture strobe when BSR selected)
// SHD  2 | shift-DR
// E1D  1 | exit1-DR
// PDR  3 | pause-DR, shift registers hold
// E2D  0 | exit2-DR
// UDR  5 | update-DR (BSC update strobe when BSR selected)
// SIR  4 | select-IR-scan
// CIR  E | capture-IR, IR shift register loads 0..01
// SHI  A | shift-IR
// E1I  9 | exit1-IR
// PIR  B | pause-IR
// E2I  8 | exit2-IR
// UIR  D | update-IR, shift register copied into IR
module tap_controller #(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic       TCK,
    input  logic       TRST_n,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSR_so,
    output logic       TDO,
    output logic       TDO_oe,
    output logic       Shift_DR,
    output logic       Mode,
    output logic       BSC_Cap_t_clk,
    output logic       BSC_Up_t_clk,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_TLR = 4'hF, ST_RTI = 4'hC, ST_SEL_DR = 4'h7, ST_CAP_DR = 4'h6,
        ST_SH_DR = 4'h2, ST_EX1_DR = 4'h1, ST_PS_DR = 4'h3, ST_EX2_DR = 4'h0,
        ST_UP_DR = 4'h5, ST_SEL_IR = 4'h4, ST_CAP_IR = 4'hE, ST_SH_IR = 4'hA,
        ST_EX1_IR = 4'h9, ST_PS_IR = 4'hB, ST_EX2_IR = 4'h8, ST_UP_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_EXTEST = '0;
    localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(1);
    localparam logic [IR_W-1:0] IR_CAP    = IR_W'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(2);
    localparam logic [IR_W-1:0] IR_RST    = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST    = '1;
`endif

    if (IR_W < 2 || IDCODE_VAL[0] != 1'b1) begin : g_bad_param
        $error("tap_controller: IR_W must be >= 2 and IDCODE_VAL[0] must be 1");
    end

    tap_state_t      cur_state, nxt_state;
    logic [IR_W-1:0] ir, ir_sr;
    logic            bypass_bit;
    logic            sel_bsr;
`ifdef TAP_IDCODE_EN
    logic [31:0]     id_sr;
    logic            sel_id;
`endif

    always_ff @(posedge TCK) begin
        if (!TRST_n) cur_state <= ST_TLR;
        else         cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = ST_TLR;
        case (cur_state)
            ST_TLR:    nxt_state = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    nxt_state = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: nxt_state = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: nxt_state = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  nxt_state = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: nxt_state = TMS ? ST_UP_DR  : ST_PS_DR;
            ST_PS_DR:  nxt_state = TMS ? ST_EX2_DR : ST_PS_DR;
            ST_EX2_DR: nxt_state = TMS ? ST_UP_DR  : ST_SH_DR;
            ST_UP_DR:  nxt_state = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: nxt_state = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: nxt_state = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  nxt_state = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: nxt_state = TMS ? ST_UP_IR  : ST_PS_IR;
            ST_PS_IR:  nxt_state = TMS ? ST_EX2_IR : ST_PS_IR;
            ST_EX2_IR: nxt_state = TMS ? ST_UP_IR  : ST_SH_IR;
            ST_UP_IR:  nxt_state = TMS ? ST_SEL_DR : ST_RTI;
            default:   nxt_state = ST_TLR;
        endcase
    end

    // TLR acts as a continuous reset of all scan registers, not just the state.
    always_ff @(posedge TCK) begin
        if (!TRST_n || cur_state == ST_TLR) begin
            ir         <= IR_RST;
            ir_sr      <= '0;
            bypass_bit <= 1'b0;
        end else begin
            case (cur_state)
                ST_CAP_IR: ir_sr <= IR_CAP;
                ST_SH_IR:  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                ST_UP_IR:  ir    <= ir_sr;
                ST_CAP_DR: bypass_bit <= 1'b0;
                ST_SH_DR:  bypass_bit <= TDI;
                default: ;
            endcase
        end
    end

`ifdef TAP_IDCODE_EN
    always_ff @(posedge TCK) begin
        if (!TRST_n || cur_state == ST_TLR) begin
            id_sr <= IDCODE_VAL;
        end else if (cur_state == ST_CAP_DR) begin
            id_sr <= IDCODE_VAL;
        end else if (cur_state == ST_SH_DR) begin
            id_sr <= {TDI, id_sr[31:1]};
        end
    end
`endif

    always_comb begin
        sel_bsr       = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
`ifdef TAP_IDCODE_EN
        sel_id        = (ir == IR_IDCODE);
`endif
        Mode          = (ir == IR_EXTEST) && (cur_state != ST_TLR);
        Shift_DR      = sel_bsr && (cur_state == ST_SH_DR);
        BSC_Cap_t_clk = sel_bsr && (cur_state == ST_CAP_DR);
        BSC_Up_t_clk  = sel_bsr && (cur_state == ST_UP_DR);
        TDO_oe        = (cur_state == ST_SH_DR) || (cur_state == ST_SH_IR);
        TDO           = 1'b0;
        if (cur_state == ST_SH_IR) begin
            TDO = ir_sr[0];
        end else if (cur_state == ST_SH_DR) begin
            if (sel_bsr) TDO = BSR_so;
`ifdef TAP_IDCODE_EN
            else if (sel_id) TDO = id_sr[0];
`endif
            else TDO = bypass_bit;
        end
    end

    assign state = cur_state;

endmodule
